// File: rtl/ocp_nic3_pwr_seq.sv
// rtl/ocp_nic3_pwr_seq.sv - OCP NIC 3.0 slot power sequencer
module ocp_nic3_pwr_seq #(
    parameter logic [15:0] AUX_TO_MAIN_DLY = 16'd1000,
    parameter logic [15:0] PERST_DLY       = 16'd1000,
    parameter logic [15:0] OFF_DLY         = 16'd100,
    parameter logic [15:0] PG_TIMEOUT      = 16'd5000
) (
    input  logic       clk_in,
    input  logic       iRst_n,
    input  logic       iClear,
    input  logic       iPwr_req,
    input  logic       iPrsnt_n,
    input  logic       iAux_pwrgd,
    input  logic       iMain_pwrgd,
    output logic       oAux_en,
    output logic       oMain_en,
    output logic       oPerst_n,
    output logic       oSeq_done,
    output logic       oSeq_fault,
    output logic [1:0] oFault_code,
    output logic [2:0] oState
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_AUX_ON    = 3'd1,
        S_MAIN_ON   = 3'd2,
        S_PERST_DLY = 3'd3,
        S_ON        = 3'd4,
        S_PWR_DOWN  = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_count;
    logic [1:0]  r_fault_code;
    logic [1:0]  w_next_code;
    logic        r_aux_en;
    logic        r_main_en;
    logic        r_perst_n;
    logic        r_seq_done;
    logic        r_seq_fault;
    logic        w_aux_en;
    logic        w_main_en;
    logic        w_perst_n;
    logic        w_pg_lost;
    logic        w_timed;

    always_comb begin
        w_next_state = r_state;
        w_next_code  = r_fault_code;
        w_pg_lost    = !iAux_pwrgd || !iMain_pwrgd;
        if (!iClear) begin
            w_next_state = S_OFF;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (iPwr_req && !iPrsnt_n) w_next_state = S_AUX_ON;
                end
                S_AUX_ON: begin
                    // A present aux PG masks the timeout, so PG wins a same-edge tie.
                    if (iPrsnt_n) begin
                        w_next_state = S_FAULT; w_next_code = 2'd3;
                    end else if (!iAux_pwrgd && r_count >= PG_TIMEOUT) begin
                        w_next_state = S_FAULT; w_next_code = 2'd1;
                    end else if (!iPwr_req) begin
                        w_next_state = S_PWR_DOWN;
                    end else if (iAux_pwrgd && r_count >= AUX_TO_MAIN_DLY) begin
                        w_next_state = S_MAIN_ON;
                    end
                end
                S_MAIN_ON: begin
                    if (iPrsnt_n || !iAux_pwrgd) begin
                        w_next_state = S_FAULT; w_next_code = 2'd3;
                    end else if (!iMain_pwrgd && r_count >= PG_TIMEOUT) begin
                        w_next_state = S_FAULT; w_next_code = 2'd2;
                    end else if (!iPwr_req) begin
                        w_next_state = S_PWR_DOWN;
                    end else if (iMain_pwrgd) begin
                        w_next_state = S_PERST_DLY;
                    end
                end
                S_PERST_DLY: begin
                    if (iPrsnt_n || w_pg_lost) begin
                        w_next_state = S_FAULT; w_next_code = 2'd3;
                    end else if (!iPwr_req) begin
                        w_next_state = S_PWR_DOWN;
                    end else if (r_count >= PERST_DLY) begin
                        w_next_state = S_ON;
                    end
                end
                S_ON: begin
                    if (iPrsnt_n || w_pg_lost) begin
                        w_next_state = S_FAULT; w_next_code = 2'd3;
                    end else if (!iPwr_req) begin
                        w_next_state = S_PWR_DOWN;
                    end
                end
                S_PWR_DOWN: begin
                    if (iPrsnt_n) begin
                        w_next_state = S_FAULT; w_next_code = 2'd3;
                    end else if (r_count >= OFF_DLY) begin
                        w_next_state = S_OFF;
                    end
                end
                S_FAULT: w_next_state = S_FAULT;
                default: begin
                    w_next_state = S_FAULT; w_next_code = 2'd3;
                end
            endcase
        end
        if (w_next_state != S_FAULT) w_next_code = 2'd0;
        w_aux_en  = (w_next_state == S_AUX_ON) || (w_next_state == S_MAIN_ON) ||
                    (w_next_state == S_PERST_DLY) || (w_next_state == S_ON) ||
                    (w_next_state == S_PWR_DOWN);
        w_main_en = (w_next_state == S_MAIN_ON) || (w_next_state == S_PERST_DLY) ||
                    (w_next_state == S_ON) || (w_next_state == S_PWR_DOWN);
        w_perst_n = (w_next_state == S_ON);
        w_timed   = (r_state == S_AUX_ON) || (r_state == S_MAIN_ON) ||
                    (r_state == S_PERST_DLY) || (r_state == S_PWR_DOWN);
    end

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state      <= S_OFF;
            r_count      <= 16'd0;
            r_fault_code <= 2'd0;
            r_aux_en     <= 1'b0;
            r_main_en    <= 1'b0;
            r_perst_n    <= 1'b0;
            r_seq_done   <= 1'b0;
            r_seq_fault  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_fault_code <= w_next_code;
            r_aux_en     <= w_aux_en;
            r_main_en    <= w_main_en;
            r_perst_n    <= w_perst_n;
            r_seq_done   <= (w_next_state == S_ON);
            r_seq_fault  <= (w_next_state == S_FAULT);
            if (w_next_state != r_state) begin
                r_count <= 16'd0;
            end else if (w_timed && r_count != 16'hFFFF) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign oAux_en     = r_aux_en;
    assign oMain_en    = r_main_en;
    assign oPerst_n    = r_perst_n;
    assign oSeq_done   = r_seq_done;
    assign oSeq_fault  = r_seq_fault;
    assign oFault_code = r_fault_code;
    assign oState      = r_state;

endmodule

// File: tb/tb_ocp_nic3_pwr_seq.sv
// tb/tb_ocp_nic3_pwr_seq.sv - scoreboard bench for ocp_nic3_pwr_seq
module tb_ocp_nic3_pwr_seq;

    logic       clk_in = 1'b0;
    logic       iRst_n;
    logic       iClear;
    logic       iPwr_req;
    logic       iPrsnt_n;
    logic       iAux_pwrgd;
    logic       iMain_pwrgd;
    logic       oAux_en;
    logic       oMain_en;
    logic       oPerst_n;
    logic       oSeq_done;
    logic       oSeq_fault;
    logic [1:0] oFault_code;
    logic [2:0] oState;

    localparam int SIG_AUX   = 0;
    localparam int SIG_MAIN  = 1;
    localparam int SIG_PERST = 2;
    localparam int SIG_FAULT = 3;
    localparam int SIG_STATE = 4;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_in = ~clk_in;

    ocp_nic3_pwr_seq #(
        .AUX_TO_MAIN_DLY(16'd10),
        .PERST_DLY      (16'd20),
        .OFF_DLY        (16'd5),
        .PG_TIMEOUT     (16'd50)
    ) dut (
        .clk_in     (clk_in),
        .iRst_n     (iRst_n),
        .iClear     (iClear),
        .iPwr_req   (iPwr_req),
        .iPrsnt_n   (iPrsnt_n),
        .iAux_pwrgd (iAux_pwrgd),
        .iMain_pwrgd(iMain_pwrgd),
        .oAux_en    (oAux_en),
        .oMain_en   (oMain_en),
        .oPerst_n   (oPerst_n),
        .oSeq_done  (oSeq_done),
        .oSeq_fault (oSeq_fault),
        .oFault_code(oFault_code),
        .oState     (oState)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    function automatic int sig(input int which);
        case (which)
            SIG_AUX:   return int'(oAux_en);
            SIG_MAIN:  return int'(oMain_en);
            SIG_PERST: return int'(oPerst_n);
            SIG_FAULT: return int'(oSeq_fault);
            default:   return int'(oState);
        endcase
    endfunction

    task automatic wait_sig(input int which, input int val, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (sig(which) != val && cyc < 300);
        if (sig(which) != val) begin
            check("wait_timeout", sig(which), val);
            cyc = -1;
        end
    endtask

    task automatic clear_pulse();
        iClear = 1'b0;
        @(negedge clk_in);
        iClear = 1'b1;
    endtask

    initial begin
        int c;
        iRst_n = 1'b0; iClear = 1'b1; iPwr_req = 1'b0; iPrsnt_n = 1'b0;
        iAux_pwrgd = 1'b0; iMain_pwrgd = 1'b0;

        // reset state
        sb_push("rst_aux", 0); sb_push("rst_main", 0); sb_push("rst_perst", 0);
        sb_push("rst_state", 0); sb_push("rst_code", 0); sb_push("rst_fault", 0);
        repeat (2) @(negedge clk_in);
        sb_pop(oAux_en); sb_pop(oMain_en); sb_pop(oPerst_n);
        sb_pop(oState); sb_pop(oFault_code); sb_pop(oSeq_fault);
        iRst_n = 1'b1;
        @(negedge clk_in);

        // normal power-up
        sb_push("up_aux_to_main", 11);
        sb_push("up_perst_dly", 21);
        sb_push("up_done", 1);
        sb_push("up_state", 4);
        iPwr_req = 1'b1;
        wait_sig(SIG_AUX, 1, c);
        repeat (3) @(negedge clk_in);
        iAux_pwrgd = 1'b1;
        wait_sig(SIG_MAIN, 1, c);
        sb_pop(c + 3);
        repeat (4) @(negedge clk_in);
        iMain_pwrgd = 1'b1;
        wait_sig(SIG_STATE, 3, c);
        wait_sig(SIG_PERST, 1, c);
        sb_pop(c);
        sb_pop(oSeq_done);
        sb_pop(oState);

        // power-down from S_ON
        sb_push("pd_perst_lat", 1);
        sb_push("pd_rails_lat", 6);
        sb_push("pd_aux", 0);
        sb_push("pd_state", 0);
        iPwr_req = 1'b0;
        wait_sig(SIG_PERST, 0, c);
        sb_pop(c);
        wait_sig(SIG_MAIN, 0, c);
        sb_pop(c);
        sb_pop(oAux_en);
        sb_pop(oState);
        iAux_pwrgd = 1'b0; iMain_pwrgd = 1'b0;
        @(negedge clk_in);

        // aux PG never arrives
        sb_push("auxto_lat", 51); sb_push("auxto_code", 1);
        sb_push("auxto_aux", 0); sb_push("auxto_main", 0); sb_push("auxto_state", 6);
        iPwr_req = 1'b1;
        wait_sig(SIG_AUX, 1, c);
        wait_sig(SIG_FAULT, 1, c);
        sb_pop(c); sb_pop(oFault_code); sb_pop(oAux_en); sb_pop(oMain_en); sb_pop(oState);
        sb_push("clr_state", 0); sb_push("clr_code", 0); sb_push("clr_fault", 0);
        iPwr_req = 1'b0;
        clear_pulse();
        sb_pop(oState); sb_pop(oFault_code); sb_pop(oSeq_fault);

        // main PG timeout, then aux PG loss in S_ON
        sb_push("mainto_lat", 51); sb_push("mainto_code", 2);
        iPwr_req = 1'b1;
        wait_sig(SIG_AUX, 1, c);
        iAux_pwrgd = 1'b1;
        wait_sig(SIG_MAIN, 1, c);
        wait_sig(SIG_FAULT, 1, c);
        sb_pop(c); sb_pop(oFault_code);
        clear_pulse();
        wait_sig(SIG_MAIN, 1, c);
        iMain_pwrgd = 1'b1;
        sb_push("on2_state", 4);
        wait_sig(SIG_STATE, 4, c);
        sb_pop(oState);
        sb_push("pglost_state", 6); sb_push("pglost_code", 3); sb_push("pglost_done", 0);
        iAux_pwrgd = 1'b0;
        @(negedge clk_in);
        sb_pop(oState); sb_pop(oFault_code); sb_pop(oSeq_done);
        iPwr_req = 1'b0; iMain_pwrgd = 1'b0;
        clear_pulse();

        // aux PG rises on the same edge the timeout is reached
        sb_push("tie_state", 2); sb_push("tie_fault", 0);
        iPwr_req = 1'b1;
        wait_sig(SIG_AUX, 1, c);
        repeat (50) @(negedge clk_in);
        iAux_pwrgd = 1'b1;
        @(negedge clk_in);
        sb_pop(oState); sb_pop(oSeq_fault);

        // async reset in S_PERST_DLY
        iMain_pwrgd = 1'b1;
        wait_sig(SIG_STATE, 3, c);
        sb_push("arst_aux", 0); sb_push("arst_main", 0); sb_push("arst_perst", 0);
        sb_push("arst_state", 0);
        #1 iRst_n = 1'b0;
        #1;
        sb_pop(oAux_en); sb_pop(oMain_en); sb_pop(oPerst_n); sb_pop(oState);
        iAux_pwrgd = 1'b0; iMain_pwrgd = 1'b0; iPwr_req = 1'b0;
        @(negedge clk_in);
        iRst_n = 1'b1;
        @(negedge clk_in);

        // card removal in S_MAIN_ON
        sb_push("rm_state", 6); sb_push("rm_code", 3); sb_push("rm_main", 0);
        iPwr_req = 1'b1;
        iAux_pwrgd = 1'b1;
        wait_sig(SIG_STATE, 2, c);
        iPrsnt_n = 1'b1;
        @(negedge clk_in);
        sb_pop(oState); sb_pop(oFault_code); sb_pop(oMain_en);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ocp_nic3_pwr_seq.md
Name: ocp_nic3_pwr_seq

Overview:
Power sequencer for one OCP NIC 3.0 slot, and the controlling side of the slot delay-timing scheme. It issues aux and main rail enables and PERST_N, times the inter-step delays itself, and watches rail power-good and card presence. It sits between the board power-request logic and the NIC slot rails and reports done/fault status to the CPLD status registers.

Parameters:
AUX_TO_MAIN_DLY, 16'd1000, minimum clocks from aux enable to main enable; aux PG must also be high.
PERST_DLY, 16'd1000, clocks from main PG to PERST_N release.
OFF_DLY, 16'd100, clocks from PERST_N assert to rails off on power-down.
PG_TIMEOUT, 16'd5000, clocks allowed for a PG to arrive after its enable.

Ports:
clk_in  input  1  sequencer clock; single clock domain.
iRst_n  input  1  asynchronous active-low reset.
iClear  input  1  active-low synchronous clear to S_OFF; clears a latched fault.
iPwr_req  input  1  1 = slot power requested.
iPrsnt_n  input  1  card present, active low; pre-synchronised.
iAux_pwrgd  input  1  aux rail power good; pre-synchronised.
iMain_pwrgd  input  1  main rail power good; pre-synchronised.
oAux_en  output  1  aux rail enable.
oMain_en  output  1  main rail enable.
oPerst_n  output  1  slot PERST_N.
oSeq_done  output  1  1 while in S_ON.
oSeq_fault  output  1  1 while in S_FAULT.
oFault_code  output  2  0 none; 1 aux PG timeout; 2 main PG timeout; 3 PG lost or card removed.
oState  output  3  encoded current state.

Behaviour:
- Reset (iRst_n=0, async): state S_OFF, count 0, all outputs 0 (oPerst_n=0), oFault_code 0.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- Timer: 16-bit count. Zeroed on every state entry. Increments once per clock in timed states and saturates at 16'hFFFF.
- A comparison against a parameter D succeeds when count==D or above. A step gated only by D therefore fires D+1 clocks after state entry.
- Priority at every edge: iClear=0 first, then fault conditions, then request drop, then normal progression.
- iClear=0 forces S_OFF from any state, turns both rails off, asserts PERST_N (oPerst_n=0) and zeroes oFault_code.
- Card removal (iPrsnt_n=1) in any state other than S_OFF or S_FAULT goes to S_FAULT with code 3.
- States (oState encoding):
  - 0 S_OFF: everything off. When iPwr_req=1 and iPrsnt_n=0, go to S_AUX_ON.
  - 1 S_AUX_ON: oAux_en=1.
    - iAux_pwrgd=1 and count reaches AUX_TO_MAIN_DLY: go to S_MAIN_ON.
    - iAux_pwrgd=0 and count reaches PG_TIMEOUT: go to S_FAULT, code 1.
    - Both conditions on the same edge: PG wins.
  - 2 S_MAIN_ON: oAux_en=1, oMain_en=1.
    - iMain_pwrgd=1: go to S_PERST_DLY.
    - iMain_pwrgd=0 and count reaches PG_TIMEOUT: go to S_FAULT, code 2.
    - iAux_pwrgd=0 at any time: go to S_FAULT, code 3.
  - 3 S_PERST_DLY: rails on, oPerst_n=0. When count reaches PERST_DLY, go to S_ON.
  - 4 S_ON: oPerst_n=1, oSeq_done=1.
    - Either PG low: go to S_FAULT, code 3.
    - Otherwise iPwr_req=0: go to S_PWR_DOWN.
  - 5 S_PWR_DOWN: oPerst_n=0 on the entry edge, rails held on. When count reaches OFF_DLY, go to S_OFF (rails off on that edge).
  - 6 S_FAULT: all enables 0, oPerst_n=0, oSeq_fault=1, oFault_code held. Leaves only via iClear=0 or reset. iPwr_req is ignored.
- iPwr_req=0 in S_AUX_ON, S_MAIN_ON or S_PERST_DLY aborts to S_PWR_DOWN.
- A re-request during S_PWR_DOWN is ignored until S_OFF is reached. From S_OFF, S_AUX_ON is entered on the next edge if the request is still high.
- PG inputs in S_PERST_DLY: a PG drop goes to S_FAULT, code 3.
- Reset mid-sequence: all outputs drop asynchronously, with no power-down delay.
- Unused encoding 7: go to S_FAULT, code 3.

Test Plan:
- Normal up: params 10/20/5/50, present, iAux_pwrgd high 3 clocks after oAux_en, iMain_pwrgd 4 clocks after oMain_en -> oMain_en 11 clocks after oAux_en; oPerst_n 1 at 21 clocks after S_PERST_DLY entry; oSeq_done=1.
- Power-down from S_ON: drop iPwr_req -> oPerst_n=0 next edge; oMain_en/oAux_en 0 six clocks later; oState=0.
- Aux PG never arrives -> S_FAULT 51 clocks after oAux_en, oFault_code=1, enables 0. Pulse iClear low one clock -> oState=0, code 0.
- Main PG timeout -> code 2. Then iAux_pwrgd drop in S_ON -> code 3 on the next edge, oSeq_done 0.
- Simultaneous aux PG rise and count==PG_TIMEOUT -> goes to S_MAIN_ON, no fault.
- Assert iRst_n low while in S_PERST_DLY -> all outputs 0 immediately. Card removal in S_MAIN_ON -> S_FAULT, code 3.
